// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the async FIFO read side.
// Provides the burst-reader state encoding, the default FIFO word width
// (shared with the FIFO instance) and a counter-width helper.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rd_state_t;

    // Index width for a counter over 0..n-1; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry {last,data} FIFO whose head is registered.
// Ports: clk, rst (async, active-high); push/push_last/push_data write side;
// pop read side; count = occupancy 0..2; head_valid/head_last/head_data
// are the registered head entry.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  head_valid,
    output logic                  head_last,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] d0_q;
    logic [DATA_WIDTH-1:0] d1_q;
    logic                  l0_q;
    logic                  l1_q;
    logic [1:0]            cnt_q;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop & (cnt_q != 2'd0);
    // A push into a full buffer is only accepted alongside a pop.
    assign do_push = push & ((cnt_q != 2'd2) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q  <= '0;
            d1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        d0_q <= push_data;
                        l0_q <= push_last;
                    end else begin
                        d1_q <= push_data;
                        l1_q <= push_last;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    // Keep the head stable when draining the last entry.
                    if (cnt_q == 2'd2) begin
                        d0_q <= d1_q;
                        l0_q <= l1_q;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        d0_q <= push_data;
                        l0_q <= push_last;
                    end else begin
                        d0_q <= d1_q;
                        l0_q <= l1_q;
                        d1_q <= push_data;
                        l1_q <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count      = cnt_q;
    assign head_valid = (cnt_q != 2'd0);
    assign head_last  = l0_q;
    assign head_data  = d0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops the async FIFO read port and emits a valid/ready
// stream tagged with m_last every BURST_LEN words; stops only on bursts.
// Ports: clk, rst (async, active-high), en run request; fifo_rd_en/
// fifo_rd_data/fifo_rd_empty FIFO read side; m_valid/m_ready/m_data/m_last
// output stream; burst_count completed bursts; busy activity flag.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BURST_LEN  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  burst_count,
    output logic                  busy
);

    localparam int            IW       = idx_width(BURST_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);

    rd_state_t            state_q;
    rd_state_t            state_d;
    logic [IW-1:0]        issue_cnt_q;
    logic [IW-1:0]        issue_cnt_d;
    logic                 issue_last;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic [1:0]           count;
    logic [2:0]           occupancy;
    logic                 pop;
    logic [CNT_WIDTH-1:0] burst_cnt_q;

    assign pop        = m_valid & m_ready;
    assign occupancy  = {1'b0, count} + {2'b00, inflight_q};
    assign issue_last = (issue_cnt_q == LAST_IDX);

    // Credit check: count + inflight - pop < 2, kept non-negative.
    assign fifo_rd_en = (state_q != IDLE) & ~fifo_rd_empty
                      & (occupancy < (3'd2 + {2'b00, pop}));

    // The stop decision looks at the post-issue count so that a read issued
    // in the same cycle as the stop is always followed by the rest of its
    // burst rather than leaving a split burst behind.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        if (fifo_rd_en) begin
            issue_cnt_d = issue_last ? '0 : issue_cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = (issue_cnt_d == '0) ? IDLE : FINISH;
                end
            end
            FINISH: begin
                if (issue_cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            burst_cnt_q     <= '0;
        end else begin
            issue_cnt_q     <= issue_cnt_d;
            inflight_q      <= fifo_rd_en;
            inflight_last_q <= fifo_rd_en & issue_last;
            if (pop && m_last) begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
            end
        end
    end

    // The word read last cycle arrives now; the credit rule guarantees room.
    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_last  (inflight_last_q),
        .push_data  (fifo_rd_data),
        .pop        (pop),
        .count      (count),
        .head_valid (m_valid),
        .head_last  (m_last),
        .head_data  (m_data)
    );

    assign burst_count = burst_cnt_q;
    assign busy        = (state_q != IDLE) | (count != 2'd0) | inflight_q;

endmodule
